// File: rtl/ps2_keymap_pkg.sv
// Scan codes, bit positions and the (ext, code) -> key-bit lookup for the
// four-player tank game held-key vector, plus the frame receiver's state codes.
package ps2_keymap_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [7:0] SC_P1_UP    = 8'h1D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;
  localparam logic [7:0] SC_P1_FIRE  = 8'h2B;
  localparam logic [7:0] SC_P2_UP    = 8'h75;
  localparam logic [7:0] SC_P2_DOWN  = 8'h72;
  localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P2_RIGHT = 8'h74;
  localparam logic [7:0] SC_P2_FIRE  = 8'h14;
  localparam logic [7:0] SC_P3_UP    = 8'h43;
  localparam logic [7:0] SC_P3_DOWN  = 8'h42;
  localparam logic [7:0] SC_P3_LEFT  = 8'h3B;
  localparam logic [7:0] SC_P3_RIGHT = 8'h4B;
  localparam logic [7:0] SC_P3_FIRE  = 8'h33;
  localparam logic [7:0] SC_P4_UP    = 8'h75;
  localparam logic [7:0] SC_P4_DOWN  = 8'h73;
  localparam logic [7:0] SC_P4_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P4_RIGHT = 8'h74;
  localparam logic [7:0] SC_P4_FIRE  = 8'h70;

  localparam logic [4:0] IDX_P1_UP    = 5'd0;
  localparam logic [4:0] IDX_P1_DOWN  = 5'd1;
  localparam logic [4:0] IDX_P1_LEFT  = 5'd2;
  localparam logic [4:0] IDX_P1_RIGHT = 5'd3;
  localparam logic [4:0] IDX_P2_UP    = 5'd4;
  localparam logic [4:0] IDX_P2_DOWN  = 5'd5;
  localparam logic [4:0] IDX_P2_LEFT  = 5'd6;
  localparam logic [4:0] IDX_P2_RIGHT = 5'd7;
  localparam logic [4:0] IDX_P3_UP    = 5'd8;
  localparam logic [4:0] IDX_P3_DOWN  = 5'd9;
  localparam logic [4:0] IDX_P3_LEFT  = 5'd10;
  localparam logic [4:0] IDX_P3_RIGHT = 5'd11;
  localparam logic [4:0] IDX_P4_UP    = 5'd12;
  localparam logic [4:0] IDX_P4_DOWN  = 5'd13;
  localparam logic [4:0] IDX_P4_LEFT  = 5'd14;
  localparam logic [4:0] IDX_P4_RIGHT = 5'd15;
  localparam logic [4:0] IDX_P1_FIRE  = 5'd16;
  localparam logic [4:0] IDX_P2_FIRE  = 5'd17;
  localparam logic [4:0] IDX_P3_FIRE  = 5'd18;
  localparam logic [4:0] IDX_P4_FIRE  = 5'd19;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } keyHit_t;

  // The ext flag separates P2's arrow keys from P4's keypad keys that share codes.
  function automatic keyHit_t lookupKey(input logic ext, input logic [7:0] code);
    keyHit_t r;
    r.hit = 1'b1;
    r.idx = 5'd0;
    case ({ext, code})
      {1'b0, SC_P1_UP}:    r.idx = IDX_P1_UP;
      {1'b0, SC_P1_DOWN}:  r.idx = IDX_P1_DOWN;
      {1'b0, SC_P1_LEFT}:  r.idx = IDX_P1_LEFT;
      {1'b0, SC_P1_RIGHT}: r.idx = IDX_P1_RIGHT;
      {1'b0, SC_P1_FIRE}:  r.idx = IDX_P1_FIRE;
      {1'b1, SC_P2_UP}:    r.idx = IDX_P2_UP;
      {1'b1, SC_P2_DOWN}:  r.idx = IDX_P2_DOWN;
      {1'b1, SC_P2_LEFT}:  r.idx = IDX_P2_LEFT;
      {1'b1, SC_P2_RIGHT}: r.idx = IDX_P2_RIGHT;
      {1'b1, SC_P2_FIRE}:  r.idx = IDX_P2_FIRE;
      {1'b0, SC_P3_UP}:    r.idx = IDX_P3_UP;
      {1'b0, SC_P3_DOWN}:  r.idx = IDX_P3_DOWN;
      {1'b0, SC_P3_LEFT}:  r.idx = IDX_P3_LEFT;
      {1'b0, SC_P3_RIGHT}: r.idx = IDX_P3_RIGHT;
      {1'b0, SC_P3_FIRE}:  r.idx = IDX_P3_FIRE;
      {1'b0, SC_P4_UP}:    r.idx = IDX_P4_UP;
      {1'b0, SC_P4_DOWN}:  r.idx = IDX_P4_DOWN;
      {1'b0, SC_P4_LEFT}:  r.idx = IDX_P4_LEFT;
      {1'b0, SC_P4_RIGHT}: r.idx = IDX_P4_RIGHT;
      {1'b0, SC_P4_FIRE}:  r.idx = IDX_P4_FIRE;
      default:             r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchroniser, falling-edge strobe,
// 11-bit frame FSM with odd-parity check and mid-frame timeout.
module ps2_rx_frame
  import ps2_keymap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_datSync;
  logic                   r_clkPrev;
  logic [1:0]             r_state;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_ones;
  logic                   r_parityOk;
  logic [TW-1:0]          r_timer;

  logic w_strobe, w_dat, w_timeout, w_badStart, w_stopDone, w_frameOk;

  // Preset to idle-high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clkSync <= '1;
      r_datSync <= '1;
      r_clkPrev <= 1'b1;
    end else begin
      r_clkSync <= {r_clkSync[SYNC_STAGES-2:0], i_ps2_clk};
      r_datSync <= {r_datSync[SYNC_STAGES-2:0], i_ps2_dat};
      r_clkPrev <= r_clkSync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_strobe   = r_clkPrev & ~r_clkSync[SYNC_STAGES-1];
    w_dat      = r_datSync[SYNC_STAGES-1];
    w_timeout  = (r_state != RX_IDLE) && !w_strobe && (r_timer == TIMEOUT_LAST);
    w_badStart = w_strobe && (r_state == RX_IDLE) && w_dat;
    w_stopDone = w_strobe && (r_state == RX_STOP);
    w_frameOk  = w_stopDone && w_dat && r_parityOk;
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_frameOk;
  assign o_err        = w_timeout | w_badStart | (w_stopDone & ~w_frameOk);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= RX_IDLE;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_ones     <= 1'b0;
      r_parityOk <= 1'b0;
      r_timer    <= '0;
    end else if (w_timeout) begin
      r_state <= RX_IDLE;
      r_timer <= '0;
    end else begin
      if (r_state == RX_IDLE || w_strobe) r_timer <= '0;
      else                                r_timer <= r_timer + 1'b1;
      if (w_strobe) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_dat) begin
              r_state  <= RX_DATA;
              r_bitCnt <= 3'd0;
              r_ones   <= 1'b0;
            end
          end
          RX_DATA: begin
            r_shift  <= {w_dat, r_shift[7:1]};
            r_ones   <= r_ones ^ w_dat;
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) r_state <= RX_PARITY;
          end
          RX_PARITY: begin
            r_parityOk <= r_ones ^ w_dat;
            r_state    <= RX_STOP;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end for the tank game: turns received bytes, with
// E0/F0 prefix tracking, into a 20-bit held-key vector.
module ps2_key_tracker
  import ps2_keymap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [19:0] keys,
  output logic [7:0]  code,
  output logic        code_valid,
  output logic        frame_err
);

  logic [7:0] w_byte;
  logic       w_byteValid;
  logic       w_err;
  keyHit_t    w_hit;

  logic [19:0] r_keys;
  logic [7:0]  r_code;
  logic        r_codeValid;
  logic        r_frameErr;
  logic        r_ext;
  logic        r_brk;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk         (clk),
    .resetn      (resetn),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_dat   (ps2_dat),
    .o_byte      (w_byte),
    .o_byte_valid(w_byteValid),
    .o_err       (w_err)
  );

  assign w_hit = lookupKey(r_ext, w_byte);

  // Prefix flags survive across bytes until a non-prefix byte or an error consumes them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_keys      <= 20'h0;
      r_code      <= 8'h00;
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
    end else begin
      r_codeValid <= 1'b0;
      r_frameErr  <= 1'b0;
      if (w_err) begin
        r_frameErr <= 1'b1;
        r_ext      <= 1'b0;
        r_brk      <= 1'b0;
      end else if (w_byteValid) begin
        r_code      <= w_byte;
        r_codeValid <= 1'b1;
        if (w_byte == PREFIX_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PREFIX_BRK) begin
          r_brk <= 1'b1;
        end else begin
          if (w_hit.hit) r_keys[w_hit.idx] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign keys       = r_keys;
  assign code       = r_code;
  assign code_valid = r_codeValid;
  assign frame_err  = r_frameErr;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed plus randomized PS/2 frames against a table-driven model of the
// key tracker; every frame is followed by a check of keys, code and pulse counts.
module tb_ps2_key_tracker;

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [19:0] keys;
  logic [7:0]  code;
  logic        code_valid;
  logic        frame_err;

  int vectors     = 0;
  int miscompares = 0;

  int         validSeen = 0;
  int         errSeen   = 0;
  logic [7:0] lastCode  = 8'h00;

  int          expValid = 0;
  int          expErr   = 0;
  logic [7:0]  expCode  = 8'h00;
  logic [19:0] expKeys  = 20'h0;
  bit          mExt     = 1'b0;
  bit          mBrk     = 1'b0;

  logic [7:0] mapCode [20];
  bit         mapExt  [20];
  logic [7:0] pool    [24];

  always #10 clk = ~clk;

  ps2_key_tracker dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .keys      (keys),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  // Pulse monitor: counts every high cycle, so a stretched pulse over-counts.
  always @(negedge clk) begin
    if (!resetn) begin
      lastCode = 8'h00;
    end else begin
      if (code_valid) begin
        validSeen++;
        lastCode = code;
      end
      if (frame_err) errSeen++;
    end
  end

  task automatic modelByte(input logic [7:0] b);
    expValid++;
    expCode = b;
    if (b == 8'hE0) mExt = 1'b1;
    else if (b == 8'hF0) mBrk = 1'b1;
    else begin
      for (int i = 0; i < 20; i++)
        if (mapExt[i] == mExt && mapCode[i] == b) expKeys[i] = !mBrk;
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic modelErr();
    expErr++;
    mExt = 1'b0;
    mBrk = 1'b0;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".keys"},     {12'h0, keys},     {12'h0, expKeys});
    checkEq({tag, ".code"},     {24'h0, code},     {24'h0, expCode});
    checkEq({tag, ".lastCode"}, {24'h0, lastCode}, {24'h0, expCode});
    checkEq({tag, ".nValid"},   32'(validSeen),    32'(expValid));
    checkEq({tag, ".nErr"},     32'(errSeen),      32'(expErr));
  endtask

  task automatic sendBit(input logic v);
    repeat (8) @(posedge clk);
    #2 ps2_dat = v;
    repeat (8) @(posedge clk);
    #2 ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    #2 ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit 0, 3 bad start, 4 truncated after 8 edges
  task automatic applyStimulus(input logic [7:0] b, input int kind);
    logic [10:0] bits;
    logic        par;
    int          n;
    par = ~(^b);
    if (kind == 1) par = ~par;
    bits = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    n = 11;
    if (kind == 3) begin
      bits[0] = 1'b1;
      n = 1;
    end
    if (kind == 4) n = 8;
    for (int i = 0; i < n; i++) sendBit(bits[i]);
    repeat (4) @(posedge clk);
    #2 ps2_dat = 1'b1;
    repeat (30) @(posedge clk);
    if (kind == 0) modelByte(b);
    else if (kind != 4) modelErr();
  endtask

  initial begin
    int kind;
    logic [7:0] b;

    mapCode = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
                8'h43, 8'h42, 8'h3B, 8'h4B, 8'h75, 8'h73, 8'h6B, 8'h74,
                8'h2B, 8'h14, 8'h33, 8'h70};
    mapExt  = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    pool    = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                8'h2B, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h43, 8'h42,
                8'h3B, 8'h4B, 8'h33, 8'h73, 8'h70, 8'hAA, 8'hE1, 8'h77};

    repeat (5) @(negedge clk);
    checkOutput("reset");
    checkEq("reset.code_valid", {31'h0, code_valid}, 32'h0);
    checkEq("reset.frame_err",  {31'h0, frame_err},  32'h0);
    resetn = 1'b1;
    repeat (5) @(posedge clk);

    applyStimulus(8'h1D, 0); checkOutput("p1up.make");
    applyStimulus(8'hF0, 0); checkOutput("p1up.brkpfx");
    applyStimulus(8'h1D, 0); checkOutput("p1up.break");

    applyStimulus(8'hE0, 0); applyStimulus(8'h75, 0); checkOutput("p2up.make");
    applyStimulus(8'h75, 0); checkOutput("p4up.make");
    applyStimulus(8'h75, 0); checkOutput("p4up.typematic");
    applyStimulus(8'hE0, 0); applyStimulus(8'hF0, 0); applyStimulus(8'h75, 0);
    checkOutput("p2up.break");

    applyStimulus(8'h1B, 1); checkOutput("parityErr");
    applyStimulus(8'h1B, 0); checkOutput("p1down.make");
    applyStimulus(8'h1B, 2); checkOutput("stopErr");
    applyStimulus(8'h00, 3); checkOutput("badStart");

    applyStimulus(8'h2B, 4);
    repeat (50100) @(posedge clk);
    modelErr();
    checkOutput("timeout");
    applyStimulus(8'h2B, 0); checkOutput("p1fire.make");

    applyStimulus(8'hF0, 0); applyStimulus(8'h75, 0); checkOutput("p4up.break");
    applyStimulus(8'hF0, 0); applyStimulus(8'h42, 0); checkOutput("breakNotHeld");
    applyStimulus(8'hE0, 0); applyStimulus(8'h75, 2); applyStimulus(8'h75, 0);
    checkOutput("errClearsExt");

    for (int i = 0; i < 30; i++) begin
      b = pool[$urandom_range(0, 23)];
      kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus(b, kind);
      checkOutput("random");
    end

    applyStimulus(8'h1D, 0); applyStimulus(8'h33, 0); checkOutput("hold.p1up.p3fire");
    applyStimulus(8'h1B, 4);
    #7 resetn = 1'b0;
    #1;
    expKeys = 20'h0;
    expCode = 8'h00;
    mExt = 1'b0;
    mBrk = 1'b0;
    checkEq("asyncReset.keys", {12'h0, keys}, 32'h0);
    checkEq("asyncReset.code", {24'h0, code}, 32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (5) @(posedge clk);
    checkOutput("afterReset");
    applyStimulus(8'h1D, 0); checkOutput("afterReset.p1up");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
